// File: rtl/convolution_processor_core.sv
// Sequencing and multiply-accumulate engine: computes Z = X * Y (full linear convolution)
// from synchronous-read X/Y memories and streams each result word into the Z memory.
module convolution_processor_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] size_x_i,
  input  logic [ADDR_WIDTH-1:0] size_y_i,
  output logic [ADDR_WIDTH-1:0] mem_x_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_x_data_i,
  output logic [ADDR_WIDTH-1:0] mem_y_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_y_data_i,
  output logic [ADDR_WIDTH:0]   mem_z_addr_o,
  output logic [ACC_WIDTH-1:0]  mem_z_data_o,
  output logic                  mem_z_we_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned IW = ADDR_WIDTH + 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_nx, r_ny, w_nx_next, w_ny_next;
  logic [ADDR_WIDTH-1:0] r_j, w_j_next;
  logic [IW-1:0]         r_i, w_i_next, w_i_last, w_k;
  logic                  w_in_range;
  logic                  r_flag, r_valid;
  logic [PW-1:0]         w_prod;
  logic [ACC_WIDTH-1:0]  w_term, r_acc, w_acc_next;
  logic [ADDR_WIDTH-1:0] r_x_addr, r_y_addr;
  logic [IW-1:0]         r_z_addr;
  logic [ACC_WIDTH-1:0]  r_z_data;
  logic                  r_z_we, r_busy, r_done;

  assign w_i_last = IW'(r_nx) + IW'(r_ny) - IW'(2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and loop-counter sequencing
  always_comb begin
    w_state_next = r_state;
    w_nx_next    = r_nx;
    w_ny_next    = r_ny;
    w_i_next     = r_i;
    w_j_next     = r_j;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_nx_next    = size_x_i;
          w_ny_next    = size_y_i;
          w_i_next     = '0;
          w_j_next     = '0;
          w_state_next = (size_x_i == '0 || size_y_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_j == r_ny - ADDR_WIDTH'(1)) w_state_next = S_DRAIN;
        else                              w_j_next     = r_j + ADDR_WIDTH'(1);
      end
      S_DRAIN: w_state_next = S_WRITE;
      S_WRITE: begin
        if (r_i == w_i_last) begin
          w_state_next = S_DONE;
        end else begin
          w_i_next     = r_i + IW'(1);
          w_j_next     = '0;
          w_state_next = S_ISSUE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // k = i - j for the address about to be issued; out-of-range terms are masked
  assign w_k        = w_i_next - IW'(w_j_next);
  assign w_in_range = (w_i_next >= IW'(w_j_next)) && (w_k < IW'(w_nx_next));

  assign w_prod = PW'(mem_x_data_i) * PW'(mem_y_data_i);
  assign w_term = r_valid ? ACC_WIDTH'(w_prod) : '0;

  // Accumulator: cleared on the first issue of a group, then one term per cycle
  always_comb begin
    w_acc_next = r_acc;
    unique case (r_state)
      S_ISSUE: w_acc_next = (r_j == '0) ? '0 : r_acc + w_term;
      S_DRAIN: w_acc_next = r_acc + w_term;
      default: w_acc_next = r_acc;
    endcase
  end

  // Datapath and registered outputs, loaded from next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nx     <= '0;
      r_ny     <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_flag   <= 1'b0;
      r_valid  <= 1'b0;
      r_x_addr <= '0;
      r_y_addr <= '0;
      r_z_addr <= '0;
      r_z_data <= '0;
      r_z_we   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_nx     <= w_nx_next;
      r_ny     <= w_ny_next;
      r_i      <= w_i_next;
      r_j      <= w_j_next;
      r_acc    <= w_acc_next;
      r_flag   <= (w_state_next == S_ISSUE) && w_in_range;
      r_valid  <= r_flag;
      r_x_addr <= ((w_state_next == S_ISSUE) && w_in_range) ? w_k[ADDR_WIDTH-1:0] : '0;
      r_y_addr <= (w_state_next == S_ISSUE) ? w_j_next : '0;
      r_z_we   <= (w_state_next == S_WRITE);
      if (w_state_next == S_WRITE) begin
        r_z_addr <= w_i_next;
        r_z_data <= w_acc_next;
      end
      r_busy   <= (w_state_next == S_ISSUE) || (w_state_next == S_DRAIN) ||
                  (w_state_next == S_WRITE);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  assign mem_x_addr_o = r_x_addr;
  assign mem_y_addr_o = r_y_addr;
  assign mem_z_addr_o = r_z_addr;
  assign mem_z_data_o = r_z_data;
  assign mem_z_we_o   = r_z_we;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule
